// File: rtl/upload_req_arbiter.sv
// rtl/upload_req_arbiter.sv - two-source arbiter feeding the upload FSM/datapath pair.
// Optional macro UPLOAD_ARB_FIXED_PRIO_EN selects fixed src0-first priority instead of round-robin.
module upload_req_arbiter #(
  parameter int          FLIT_W   = 16,
  parameter int          CNT_W    = 4,
  parameter logic [1:0]  FSM_IDLE = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src0_v,
  input  logic [FLIT_W-1:0] src0_head_flit,
  input  logic [FLIT_W-1:0] src0_addrhi,
  input  logic [FLIT_W-1:0] src0_addrlo,
  input  logic [CNT_W-1:0]  src0_flits_max,
  input  logic [CNT_W-1:0]  src0_inv_ids,
  input  logic              src0_en_inv_ids,
  output logic              src0_ack,
  input  logic              src1_v,
  input  logic [FLIT_W-1:0] src1_head_flit,
  input  logic [FLIT_W-1:0] src1_addrhi,
  input  logic [FLIT_W-1:0] src1_addrlo,
  input  logic [CNT_W-1:0]  src1_flits_max,
  input  logic [CNT_W-1:0]  src1_inv_ids,
  input  logic              src1_en_inv_ids,
  output logic              src1_ack,
  input  logic [1:0]        upl_fsm_state,
  output logic              upl_v_flits,
  output logic [FLIT_W-1:0] upl_head_flit,
  output logic [FLIT_W-1:0] upl_addrhi,
  output logic [FLIT_W-1:0] upl_addrlo,
  output logic [CNT_W-1:0]  upl_flits_max,
  output logic [CNT_W-1:0]  upl_inv_ids,
  output logic              upl_en_inv_ids,
  output logic              grant_id,
  output logic              arb_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_START = 2'b10,
    S_BUSY  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic [FLIT_W-1:0]   head_q, head_d;
  logic [FLIT_W-1:0]   addrhi_q, addrhi_d;
  logic [FLIT_W-1:0]   addrlo_q, addrlo_d;
  logic [CNT_W-1:0]    fmax_q, fmax_d;
  logic [CNT_W-1:0]    inv_q, inv_d;
  logic                en_inv_q, en_inv_d;
  logic                win;

`ifdef UPLOAD_ARB_FIXED_PRIO_EN
  assign win = ~src0_v;
`else
  logic last_grant_q, last_grant_d;

  // With both pending, the source not served last time wins; otherwise the lone requester wins.
  assign win = (src0_v & src1_v) ? ~last_grant_q : ~src0_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    head_d   = head_q;
    addrhi_d = addrhi_q;
    addrlo_d = addrlo_q;
    fmax_d   = fmax_q;
    inv_d    = inv_q;
    en_inv_d = en_inv_q;
`ifndef UPLOAD_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (src0_v | src1_v) begin
          state_d  = S_LOAD;
          grant_d  = win;
          head_d   = win ? src1_head_flit  : src0_head_flit;
          addrhi_d = win ? src1_addrhi     : src0_addrhi;
          addrlo_d = win ? src1_addrlo     : src0_addrlo;
          fmax_d   = win ? src1_flits_max  : src0_flits_max;
          inv_d    = win ? src1_inv_ids    : src0_inv_ids;
          en_inv_d = win ? src1_en_inv_ids : src0_en_inv_ids;
        end
      end
      S_LOAD: state_d = S_START;
      S_START: begin
        if (upl_fsm_state != FSM_IDLE) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (upl_fsm_state == FSM_IDLE) begin
          state_d = S_IDLE;
`ifndef UPLOAD_ARB_FIXED_PRIO_EN
          last_grant_d = grant_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      head_q   <= '0;
      addrhi_q <= '0;
      addrlo_q <= '0;
      fmax_q   <= '0;
      inv_q    <= '0;
      en_inv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      head_q   <= head_d;
      addrhi_q <= addrhi_d;
      addrlo_q <= addrlo_d;
      fmax_q   <= fmax_d;
      inv_q    <= inv_d;
      en_inv_q <= en_inv_d;
    end
  end

  // Strobe and ack are decoded from LOAD so each fires for exactly one cycle per grant.
  assign upl_v_flits    = (state_q == S_LOAD);
  assign src0_ack       = (state_q == S_LOAD) & ~grant_q;
  assign src1_ack       = (state_q == S_LOAD) &  grant_q;
  assign arb_busy       = (state_q != S_IDLE);
  assign grant_id       = grant_q;
  assign upl_head_flit  = head_q;
  assign upl_addrhi     = addrhi_q;
  assign upl_addrlo     = addrlo_q;
  assign upl_flits_max  = fmax_q;
  assign upl_inv_ids    = inv_q;
  assign upl_en_inv_ids = en_inv_q;

endmodule

// File: tb/tb_upload_req_arbiter.sv
// tb/tb_upload_req_arbiter.sv - directed self-checking bench for upload_req_arbiter.
module tb_upload_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        src0_v, src1_v;
  logic [15:0] src0_head_flit, src0_addrhi, src0_addrlo;
  logic [15:0] src1_head_flit, src1_addrhi, src1_addrlo;
  logic [3:0]  src0_flits_max, src0_inv_ids, src1_flits_max, src1_inv_ids;
  logic        src0_en_inv_ids, src1_en_inv_ids;
  logic        src0_ack, src1_ack;
  logic [1:0]  upl_fsm_state;
  logic        upl_v_flits;
  logic [15:0] upl_head_flit, upl_addrhi, upl_addrlo;
  logic [3:0]  upl_flits_max, upl_inv_ids;
  logic        upl_en_inv_ids, grant_id, arb_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  upload_req_arbiter dut (
    .clk(clk), .rst(rst),
    .src0_v(src0_v), .src0_head_flit(src0_head_flit), .src0_addrhi(src0_addrhi),
    .src0_addrlo(src0_addrlo), .src0_flits_max(src0_flits_max), .src0_inv_ids(src0_inv_ids),
    .src0_en_inv_ids(src0_en_inv_ids), .src0_ack(src0_ack),
    .src1_v(src1_v), .src1_head_flit(src1_head_flit), .src1_addrhi(src1_addrhi),
    .src1_addrlo(src1_addrlo), .src1_flits_max(src1_flits_max), .src1_inv_ids(src1_inv_ids),
    .src1_en_inv_ids(src1_en_inv_ids), .src1_ack(src1_ack),
    .upl_fsm_state(upl_fsm_state), .upl_v_flits(upl_v_flits),
    .upl_head_flit(upl_head_flit), .upl_addrhi(upl_addrhi), .upl_addrlo(upl_addrlo),
    .upl_flits_max(upl_flits_max), .upl_inv_ids(upl_inv_ids),
    .upl_en_inv_ids(upl_en_inv_ids), .grant_id(grant_id), .arb_busy(arb_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks the upload FSM 00->01->10->00 starting from START; returns with the arbiter in IDLE.
  task automatic finish_upload();
    tick();
    upl_fsm_state = 2'b01;
    tick();
    upl_fsm_state = 2'b10;
    tick();
    upl_fsm_state = 2'b00;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    src0_v = 0; src1_v = 0;
    src0_head_flit = '0; src0_addrhi = '0; src0_addrlo = '0;
    src1_head_flit = '0; src1_addrhi = '0; src1_addrlo = '0;
    src0_flits_max = '0; src0_inv_ids = '0; src0_en_inv_ids = 0;
    src1_flits_max = '0; src1_inv_ids = '0; src1_en_inv_ids = 0;
    upl_fsm_state = 2'b00;
    tick();
    tick();
    check("rst_busy", arb_busy, 0);
    check("rst_vflits", upl_v_flits, 0);
    check("rst_acks", {src0_ack, src1_ack}, 0);
    check("rst_grant", grant_id, 0);
    check("rst_head", upl_head_flit, 0);
    rst = 1'b0;

    // Single src0 request
    src0_v = 1; src0_head_flit = 16'h1234; src0_addrhi = 16'h00A1; src0_addrlo = 16'h00B2;
    src0_flits_max = 4'd2;
    tick();
    check("t1_vflits", upl_v_flits, 1);
    check("t1_ack", {src0_ack, src1_ack}, 2'b10);
    check("t1_head", upl_head_flit, 16'h1234);
    check("t1_addr", {upl_addrhi, upl_addrlo}, 32'h00A1_00B2);
    check("t1_fmax", upl_flits_max, 2);
    check("t1_grant", grant_id, 0);
    src0_v = 0;
    tick();
    check("t1_start_vflits", upl_v_flits, 0);
    check("t1_start_busy", arb_busy, 1);
    upl_fsm_state = 2'b01; tick();
    upl_fsm_state = 2'b10; tick();
    upl_fsm_state = 2'b00; tick();
    check("t1_idle_busy", arb_busy, 0);
    check("t1_idle_hold", upl_head_flit, 16'h1234);

    // Reset restores last_grant=1, then a dual request
    rst = 1; tick(); rst = 0;
    src0_v = 1; src0_head_flit = 16'hAAAA;
    src1_v = 1; src1_head_flit = 16'hBBBB;
    tick();
    check("t2_ack0", {src0_ack, src1_ack}, 2'b10);
    check("t2_grant0", grant_id, 0);
    check("t2_head0", upl_head_flit, 16'hAAAA);
    src0_v = 0;
    tick();
    check("t2_src1_wait", src1_ack, 0);
    upl_fsm_state = 2'b01; tick();
    upl_fsm_state = 2'b10; tick();
    upl_fsm_state = 2'b00; tick();
    check("t2_m1_idle", {arb_busy, src1_ack, upl_v_flits}, 0);
    tick();
    check("t2_m2_ack1", {src0_ack, src1_ack, upl_v_flits}, 3'b011);
    check("t2_grant1", grant_id, 1);
    check("t2_head1", upl_head_flit, 16'hBBBB);
    src1_v = 0;
    finish_upload();

    // Third dual request goes to src0, then upload FSM stalls in idle
    src0_v = 1; src0_head_flit = 16'h5555;
    src1_v = 1; src1_head_flit = 16'hCCCC; src1_inv_ids = 4'b1010; src1_en_inv_ids = 1;
    tick();
    check("t3_grant", grant_id, 0);
    check("t3_ack", {src0_ack, src1_ack}, 2'b10);
    src0_v = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_busy", arb_busy, 1);
      check("stall_strobe", {upl_v_flits, src0_ack, src1_ack}, 0);
    end
    upl_fsm_state = 2'b01; tick();
    check("busy_state", arb_busy, 1);

    // Reset mid-packet
    rst = 1; tick();
    check("abort_busy", arb_busy, 0);
    check("abort_fields", {upl_head_flit, upl_flits_max, upl_inv_ids, upl_en_inv_ids}, 0);
    check("abort_acks", {src0_ack, src1_ack, upl_v_flits, grant_id}, 0);
    rst = 0; upl_fsm_state = 2'b00;
    tick();
    check("t4_ack1", {src0_ack, src1_ack}, 2'b01);
    check("t4_grant", grant_id, 1);
    check("t4_inv", {upl_en_inv_ids, upl_inv_ids}, 5'b1_1010);
    check("t4_head", upl_head_flit, 16'hCCCC);
    src1_v = 0; src1_inv_ids = 4'b0101; src1_en_inv_ids = 0;
    tick();
    check("t4_inv_start", {upl_en_inv_ids, upl_inv_ids}, 5'b1_1010);
    upl_fsm_state = 2'b01; tick();
    check("t4_inv_busy", {upl_en_inv_ids, upl_inv_ids}, 5'b1_1010);
    upl_fsm_state = 2'b00; tick();
    check("t4_idle", arb_busy, 0);
    check("t4_inv_idle", {upl_en_inv_ids, upl_inv_ids}, 5'b1_1010);

    // last_grant=1: dual goes to src0, then the following dual distinguishes priority modes
    src0_v = 1; src1_v = 1; src0_head_flit = 16'h0F0F;
    tick();
    check("t5_grant_a", grant_id, 0);
    src0_v = 0; src1_v = 0;
    finish_upload();
    src0_v = 1; src1_v = 1;
    tick();
`ifdef UPLOAD_ARB_FIXED_PRIO_EN
    check("t5_grant_b", {grant_id, src0_ack, src1_ack}, 3'b010);
`else
    check("t5_grant_b", {grant_id, src0_ack, src1_ack}, 3'b101);
`endif
    src0_v = 0; src1_v = 0;
    finish_upload();
    check("t5_end_idle", arb_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
